// File: rtl/flap_controller.sv
// flap_controller: drives one split-flap character module.
// Accepts a target position over a valid/ready handshake, holds the flap
// timer cleared while idle, then issues one flap_step per timer trigger,
// stepping forward only (wrapping at NUM_CHARS) until the tracked position
// equals the target.
// Optional feature macro: FLAP_HOME_SENSOR_EN adds a home_sensor input that
// resynchronises the tracked position to 0 and a position_err pulse output.
//
// Handshake: a target transfers on a rising clk edge where target_valid and
// target_ready are both high. target_ready is high only in IDLE, so the
// requester must hold target_valid (and target_char) until it sees ready.
// target_valid is ignored in every other state; nothing is queued.
module flap_controller #(
  parameter int NUM_CHARS = 40,
  parameter int CHAR_W    = 6
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              target_valid,
  input  logic [CHAR_W-1:0] target_char,
  output logic              target_ready,
  input  logic              trigger,
  output logic              timer_clear,
  output logic              timer_enable,
  output logic              flap_step,
  output logic [CHAR_W-1:0] current_char,
  output logic              busy,
  output logic              done,
  output logic              target_err
`ifdef FLAP_HOME_SENSOR_EN
  ,
  input  logic              home_sensor,
  output logic              position_err
`endif
);

  localparam logic [CHAR_W-1:0] LAST_POS = CHAR_W'(NUM_CHARS - 1);
  localparam logic [CHAR_W:0]   NUM_EXT  = (CHAR_W + 1)'(NUM_CHARS);

  // Encoding is visible to checkers through state_q.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_TICK = 2'd2,
    FINISH    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CHAR_W-1:0] cur_q, cur_d;
  logic [CHAR_W-1:0] tgt_q, tgt_d;
  logic              flap_step_q, flap_step_d;
  logic              done_q, done_d;
  logic              target_err_q, target_err_d;
  logic              timer_clear_q, timer_clear_d;
  logic              timer_enable_q, timer_enable_d;
  logic              pos_err_q, pos_err_d;

  logic              handshake;
  logic              tgt_bad;
  logic              step;
  logic              resync;
  logic [CHAR_W-1:0] base_pos;
  logic [CHAR_W-1:0] pos_next;

  // Handshake and target legality.
  assign handshake = target_valid & target_ready;
  assign tgt_bad   = ({1'b0, target_char} >= NUM_EXT);

  // A trigger only counts while waiting for a tick.
  assign step = (state_q == WAIT_TICK) & trigger;

`ifdef FLAP_HOME_SENSOR_EN
  // The sensor is looked at while the step pulse is out; a mismatch forces 0.
  assign resync = flap_step_q & home_sensor & (cur_q != '0);
`else
  assign resync = 1'b0;
`endif

  // Resync applies before any step taken in the same cycle.
  assign base_pos = resync ? '0 : cur_q;
  assign pos_next = step ? ((base_pos == LAST_POS) ? '0 : base_pos + 1'b1) : base_pos;

  // State register.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (handshake && !tgt_bad) begin
          state_d = (target_char == base_pos) ? FINISH : ARM;
        end
      end
      ARM:       state_d = WAIT_TICK;
      WAIT_TICK: begin
        if ((step || resync) && (pos_next == tgt_q)) begin
          state_d = FINISH;
        end
      end
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    tgt_d = tgt_q;
    if (handshake && !tgt_bad) begin
      tgt_d = target_char;
    end
    cur_d          = pos_next;
    flap_step_d    = step;
    done_d         = (state_q == FINISH);
    target_err_d   = handshake & tgt_bad;
    timer_clear_d  = (state_d != WAIT_TICK);
    timer_enable_d = (state_d == WAIT_TICK);
    pos_err_d      = resync;
  end

  // Output and datapath registers; reset holds the timer cleared.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cur_q          <= '0;
      tgt_q          <= '0;
      flap_step_q    <= 1'b0;
      done_q         <= 1'b0;
      target_err_q   <= 1'b0;
      timer_clear_q  <= 1'b1;
      timer_enable_q <= 1'b0;
      pos_err_q      <= 1'b0;
    end else begin
      cur_q          <= cur_d;
      tgt_q          <= tgt_d;
      flap_step_q    <= flap_step_d;
      done_q         <= done_d;
      target_err_q   <= target_err_d;
      timer_clear_q  <= timer_clear_d;
      timer_enable_q <= timer_enable_d;
      pos_err_q      <= pos_err_d;
    end
  end

  // ready is masked during reset so nothing is accepted while it is held.
  assign target_ready = (state_q == IDLE) & ~sync_reset;
  assign busy         = (state_q != IDLE);
  assign timer_clear  = timer_clear_q;
  assign timer_enable = timer_enable_q;
  assign flap_step    = flap_step_q;
  assign current_char = cur_q;
  assign done         = done_q;
  assign target_err   = target_err_q;

`ifdef FLAP_HOME_SENSOR_EN
  assign position_err = pos_err_q;
`else
  // Without the sensor there is never a resync to report.
  logic unused_pos_err;
  assign unused_pos_err = pos_err_q;
`endif

endmodule

// File: tb/tb_flap_controller.sv
// tb_flap_controller: directed vectors for flap_controller (NUM_CHARS=40).
// A table of one-cycle records covers reset, a 0->5 move, a rejected target,
// a 5->7 move and a 7->7 no-step move; hand-written sequences cover the long
// move to 38, the wrapping move 38->2, reset mid-move and the home sensor.
module tb_flap_controller;

  logic       clk;
  logic       sync_reset;
  logic       target_valid;
  logic [5:0] target_char;
  logic       target_ready;
  logic       trigger;
  logic       timer_clear;
  logic       timer_enable;
  logic       flap_step;
  logic [5:0] current_char;
  logic       busy;
  logic       done;
  logic       target_err;
`ifdef FLAP_HOME_SENSOR_EN
  logic       home_sensor;
  logic       position_err;
`endif

  flap_controller #(.NUM_CHARS(40), .CHAR_W(6)) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .target_valid (target_valid),
    .target_char  (target_char),
    .target_ready (target_ready),
    .trigger      (trigger),
    .timer_clear  (timer_clear),
    .timer_enable (timer_enable),
    .flap_step    (flap_step),
    .current_char (current_char),
    .busy         (busy),
    .done         (done),
    .target_err   (target_err)
`ifdef FLAP_HOME_SENSOR_EN
    ,
    .home_sensor  (home_sensor),
    .position_err (position_err)
`endif
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One record: inputs applied for one cycle, outputs expected after the edge.
  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [5:0] ch;
    logic       trig;
    logic       ready;
    logic       busy;
    logic       clr;
    logic       en;
    logic       step;
    logic [5:0] cur;
    logic       done;
    logic       err;
  } vec_t;

  vec_t       vec_q[$];
  logic [5:0] exp_q[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [5:0] model_pos = 6'd0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [5:0] c, input logic t);
    sync_reset   = r;
    target_valid = v;
    target_char  = c;
    trigger      = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic v, input logic [5:0] c, input logic t,
                     input logic rdy, input logic bsy, input logic clr, input logic en,
                     input logic stp, input logic [5:0] cur, input logic dn, input logic er);
    vec_t x;
    x.rst = r; x.valid = v; x.ch = c; x.trig = t;
    x.ready = rdy; x.busy = bsy; x.clr = clr; x.en = en;
    x.step = stp; x.cur = cur; x.done = dn; x.err = er;
    vec_q.push_back(x);
  endtask

  // Full move driven by a trigger every cycle; expected positions come from
  // the bench's own forward-wrap model.
  task automatic do_move(input logic [5:0] tgt, input string name);
    logic [5:0] p;
    logic [5:0] e;
    int         nexp;
    int         nsteps;
    logic       seen_done;
    p = model_pos;
    exp_q.delete();
    while (p != tgt) begin
      p = (p == 6'd39) ? 6'd0 : p + 6'd1;
      exp_q.push_back(p);
    end
    nexp = exp_q.size();
    cycle(1'b0, 1'b1, tgt, 1'b0);
    chk({name, "_arm_busy"}, busy, 1);
    chk({name, "_arm_clear"}, timer_clear, 1);
    cycle(1'b0, 1'b0, 6'd0, 1'b0);
    chk({name, "_wait_enable"}, timer_enable, 1);
    nsteps    = 0;
    seen_done = 1'b0;
    for (int g = 0; g < 200 && !seen_done; g++) begin
      cycle(1'b0, 1'b0, 6'd0, 1'b1);
      if (flap_step) begin
        nsteps++;
        if (exp_q.size() == 0) begin
          chk({name, "_extra_step"}, nsteps, nexp);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s_pos%0d", name, nsteps), current_char, e);
        end
      end
      if (done) seen_done = 1'b1;
    end
    chk({name, "_steps"}, nsteps, nexp);
    chk({name, "_done_seen"}, seen_done, 1);
    chk({name, "_final_pos"}, current_char, tgt);
    chk({name, "_ready_back"}, target_ready, 1);
    model_pos = tgt;
  endtask

  initial begin
    vec_t v;
    sync_reset   = 1'b1;
    target_valid = 1'b0;
    target_char  = 6'd0;
    trigger      = 1'b0;
`ifdef FLAP_HOME_SENSOR_EN
    home_sensor  = 1'b0;
`endif

    //   rst v  ch     tr   rdy bsy clr en  stp cur    dn  er
    add(1, 0, 6'd0,  0,   0,  0,  1,  0,  0,  6'd0,  0,  0);  // reset
    add(0, 1, 6'd5,  0,   0,  1,  1,  0,  0,  6'd0,  0,  0);  // accept 5 -> ARM
    add(0, 0, 6'd0,  0,   0,  1,  0,  1,  0,  6'd0,  0,  0);  // WAIT_TICK
    add(0, 0, 6'd0,  1,   0,  1,  0,  1,  1,  6'd1,  0,  0);
    add(0, 0, 6'd0,  0,   0,  1,  0,  1,  0,  6'd1,  0,  0);
    add(0, 0, 6'd0,  1,   0,  1,  0,  1,  1,  6'd2,  0,  0);
    add(0, 0, 6'd0,  1,   0,  1,  0,  1,  1,  6'd3,  0,  0);
    add(0, 0, 6'd0,  1,   0,  1,  0,  1,  1,  6'd4,  0,  0);
    add(0, 0, 6'd0,  0,   0,  1,  0,  1,  0,  6'd4,  0,  0);
    add(0, 0, 6'd0,  1,   0,  1,  1,  0,  1,  6'd5,  0,  0);  // 5th step -> FINISH
    add(0, 0, 6'd0,  1,   1,  0,  1,  0,  0,  6'd5,  1,  0);  // trigger ignored, done
    add(0, 0, 6'd0,  0,   1,  0,  1,  0,  0,  6'd5,  0,  0);
    add(0, 1, 6'd45, 0,   1,  0,  1,  0,  0,  6'd5,  0,  1);  // rejected target
    add(0, 0, 6'd0,  0,   1,  0,  1,  0,  0,  6'd5,  0,  0);
    add(0, 1, 6'd7,  0,   0,  1,  1,  0,  0,  6'd5,  0,  0);  // accept 7 -> ARM
    add(0, 0, 6'd0,  0,   0,  1,  0,  1,  0,  6'd5,  0,  0);
    add(0, 1, 6'd20, 1,   0,  1,  0,  1,  1,  6'd6,  0,  0);  // valid ignored while busy
    add(0, 0, 6'd0,  1,   0,  1,  1,  0,  1,  6'd7,  0,  0);  // reached 7 -> FINISH
    add(0, 0, 6'd0,  0,   1,  0,  1,  0,  0,  6'd7,  1,  0);  // done
    add(0, 1, 6'd7,  0,   0,  1,  1,  0,  0,  6'd7,  0,  0);  // 7->7 -> FINISH
    add(0, 0, 6'd0,  1,   1,  0,  1,  0,  0,  6'd7,  1,  0);  // done, no step
    add(0, 0, 6'd0,  0,   1,  0,  1,  0,  0,  6'd7,  0,  0);

    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      cycle(v.rst, v.valid, v.ch, v.trig);
      chk($sformatf("v%0d_ready", i), target_ready, v.ready);
      chk($sformatf("v%0d_busy", i), busy, v.busy);
      chk($sformatf("v%0d_clear", i), timer_clear, v.clr);
      chk($sformatf("v%0d_enable", i), timer_enable, v.en);
      chk($sformatf("v%0d_step", i), flap_step, v.step);
      chk($sformatf("v%0d_cur", i), current_char, v.cur);
      chk($sformatf("v%0d_done", i), done, v.done);
      chk($sformatf("v%0d_err", i), target_err, v.err);
    end
    model_pos = 6'd7;

    // Long move to 38, then the wrapping move 38 -> 39,0,1,2.
    do_move(6'd38, "mv38");
    do_move(6'd2, "wrap");

    // Reset after 3 of 10 steps (2 -> 12).
    cycle(1'b0, 1'b1, 6'd12, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 6'd0, 1'b1);
    chk("rst_mid_pos", current_char, 5);
    cycle(1'b1, 1'b0, 6'd0, 1'b0);
    chk("rst_cur", current_char, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready_low", target_ready, 0);
    cycle(1'b0, 1'b0, 6'd0, 1'b0);
    chk("rst_after_clear", timer_clear, 1);
    chk("rst_after_enable", timer_enable, 0);
    chk("rst_after_ready", target_ready, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 6'd0, 1'b1);
      chk($sformatf("rst_quiet_done%0d", k), done, 0);
      chk($sformatf("rst_quiet_step%0d", k), flap_step, 0);
      chk($sformatf("rst_quiet_cur%0d", k), current_char, 0);
    end
    model_pos = 6'd0;

`ifdef FLAP_HOME_SENSOR_EN
    // Home sensor fires after the step that computed 3 (target 10).
    begin
      int   nsteps;
      logic seen_done;
      cycle(1'b0, 1'b1, 6'd10, 1'b0);
      cycle(1'b0, 1'b0, 6'd0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 6'd0, 1'b1);
      chk("hs_pre_pos", current_char, 3);
      chk("hs_pre_step", flap_step, 1);
      home_sensor = 1'b1;
      cycle(1'b0, 1'b0, 6'd0, 1'b0);
      home_sensor = 1'b0;
      chk("hs_pos_err", position_err, 1);
      chk("hs_resync_pos", current_char, 0);
      nsteps    = 0;
      seen_done = 1'b0;
      for (int g = 0; g < 100 && !seen_done; g++) begin
        cycle(1'b0, 1'b0, 6'd0, 1'b1);
        if (flap_step) nsteps++;
        if (done) seen_done = 1'b1;
      end
      chk("hs_steps", nsteps, 10);
      chk("hs_done", seen_done, 1);
      chk("hs_final", current_char, 10);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/flap_controller.md
Name: flap_controller

Overview:
- Drives one split-flap character module. It is the consumer end of the flap timer interface: it drives the timer's clear/enable inputs and consumes its one-cycle trigger.
- Accepts a target character over a valid/ready handshake.
- Issues one flap_step pulse per timer trigger until the tracked position equals the target, stepping forward only and wrapping through NUM_CHARS.

Parameters:
- NUM_CHARS, 40, number of flaps on the drum; positions are 0..NUM_CHARS-1.
- CHAR_W, 6, width of the position/target fields; must satisfy 2^CHAR_W >= NUM_CHARS.

Ports:
- clk  input  1  system clock.
- sync_reset  input  1  synchronous, active-high reset, sampled on rising clk.
- target_valid  input  1  target_char is valid.
- target_char  input  CHAR_W  requested position.
- target_ready  output  1  controller can accept a target (IDLE only).
- trigger  input  1  timer period-elapsed pulse.
- timer_clear  output  1  clears the timer counter.
- timer_enable  output  1  lets the timer count.
- flap_step  output  1  one-cycle pulse that advances the drum by one flap.
- current_char  output  CHAR_W  tracked drum position.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the target is reached.
- target_err  output  1  one-cycle pulse when a target is rejected.

Behaviour:
- Decided: one clock, clk; sync_reset is synchronous and active-high.
- Reset values:
  - state=IDLE, current_char=0, target_reg=0.
  - All pulses low, timer_enable=0, timer_clear=1. The timer is held cleared while in reset and IDLE.
  - target_ready=0 during reset and 1 in the first cycle after reset.
- All outputs are registered except target_ready and busy, which decode directly from state.
- FSM states: IDLE, ARM, WAIT_TICK, FINISH.
- IDLE:
  - target_ready=1, timer_clear=1, timer_enable=0.
  - A handshake (valid and ready) captures target_char into target_reg.
  - target_char >= NUM_CHARS: target_err pulses next cycle; stay in IDLE; no other effect.
  - target_char == current_char: go to FINISH; no steps are issued.
  - Otherwise: go to ARM.
- ARM (1 cycle): timer_clear=1, timer_enable=0, then go to WAIT_TICK. This guarantees a full timer period before the first step.
- WAIT_TICK:
  - timer_clear=0, timer_enable=1.
  - When trigger is sampled high:
    - flap_step=1 in the next cycle (1-cycle latency).
    - current_char updates in that same cycle: current_char+1, or 0 if current_char==NUM_CHARS-1 (wrap).
  - If the new position == target_reg, go to FINISH; otherwise stay in WAIT_TICK with the timer still running (no re-clear).
- FINISH (1 cycle): done=1, timer_clear=1, timer_enable=0, then go to IDLE.
- trigger is ignored outside WAIT_TICK.
- target_valid is ignored while busy. No queueing: the requester must hold valid until ready.
- The step count for a move equals (target - start) mod NUM_CHARS.
- sync_reset asserted mid-move aborts the move: current_char returns to 0 and no done pulse is issued.
- Back-to-back:
  - A target may be accepted in the cycle after done.
  - A trigger arriving in the same cycle as the FINISH transition produces no extra step.

Optional Feature:
- Macro FLAP_HOME_SENSOR_EN.
- Defined:
  - Adds input home_sensor (1 bit), high when the physical drum sits at flap 0. It is sampled in the cycle after each flap_step.
  - If home_sensor=1 and current_char!=0: current_char is forced to 0, and position_err (new 1-bit output) pulses once.
  - The move then continues toward target_reg from the resynced position.
- Not defined:
  - No home_sensor or position_err ports.
  - Position is tracked by counting steps only.

Test Plan:
- Reset, then target 5 from position 0 -> ARM shows timer_clear=1 for 1 cycle; exactly 5 flap_step pulses, each 1 cycle after a trigger; current_char=5; done pulses once; target_ready returns to 1.
- Position 38 (NUM_CHARS=40), target 2 -> 4 steps with sequence 39,0,1,2; done asserted.
- Target equal to current (7->7) -> no flap_step; timer_enable stays 0; done 2 cycles after the handshake.
- Target 45 -> target_err pulse; state stays IDLE; current_char unchanged; no timer activity.
- sync_reset asserted after 3 of 10 steps -> current_char=0, busy=0, no done; timer_clear=1 the next cycle.
- FLAP_HOME_SENSOR_EN: home_sensor=1 after a step that computed position 3 (target 10) -> position_err pulse; current_char=0; 10 further steps, then done.
